// File: rtl/arrow_stream_scheduler.sv
// Scrolls both players' 26-slot arrow lanes, judges button presses against the
// hit window and keeps per-player judgment indicators and saturating scores.
module arrow_stream_scheduler #(
   parameter int FRAMES_PER_STEP = 4,
   parameter int INDICATOR_HOLD  = 30,
   parameter int JUDGE_SLOT      = 22
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic        frame_tick,
   input  logic        arrow_valid,
   input  logic [2:0]  arrow_code,
   output logic        arrow_ready,
   input  logic        p1_press_valid,
   input  logic [2:0]  p1_press_code,
   input  logic        p2_press_valid,
   input  logic [2:0]  p2_press_code,
   output logic [77:0] p1_arrow_array,
   output logic [77:0] p2_arrow_array,
   output logic [1:0]  p1_indicator,
   output logic [1:0]  p2_indicator,
   output logic [15:0] p1_score,
   output logic [15:0] p2_score,
   output logic        step
);

   localparam int         ARRAY_W   = 78;
   localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
   localparam logic [7:0] HOLD_INIT = 8'(INDICATOR_HOLD);

   localparam logic [1:0] IND_NONE      = 2'b00;
   localparam logic [1:0] IND_BAD       = 2'b01;
   localparam logic [1:0] IND_GOOD      = 2'b10;
   localparam logic [1:0] IND_EXCELLENT = 2'b11;

   logic [7:0]  frame_cnt;
   logic        step_cycle;
   logic [2:0]  load_code;

   logic        press_valid [2];
   logic [2:0]  press_code  [2];

   logic [77:0] arr_q       [2];
   logic [77:0] arr_clr     [2];
   logic [77:0] arr_nxt     [2];
   logic [1:0]  ind_q       [2];
   logic [7:0]  hold_q      [2];
   logic [15:0] score_q     [2];
   logic [15:0] score_nxt   [2];
   logic [16:0] score_sum   [2];
   logic [1:0]  score_add   [2];
   logic        judged      [2];
   logic [1:0]  judge_ind   [2];
   logic        miss        [2];

   function automatic logic is_legal(input logic [2:0] code);
      case (code)
         3'b001, 3'b010, 3'b011, 3'b100, 3'b110: is_legal = 1'b1;
         default:                                is_legal = 1'b0;
      endcase
   endfunction

   assign press_valid[0] = p1_press_valid;
   assign press_valid[1] = p2_press_valid;
   assign press_code[0]  = p1_press_code;
   assign press_code[1]  = p2_press_code;

   // Reset masks the step so the pattern source never sees a handshake it loses.
   assign step_cycle  = run & frame_tick & (frame_cnt == STEP_LAST) & ~reset;
   assign arrow_ready = step_cycle;
   assign load_code   = (arrow_valid && is_legal(arrow_code)) ? arrow_code : 3'b000;

   // Press clears the hit slot first, then the step shifts the cleared lane,
   // so a miss is only reported for an arrow nobody hit.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         arr_clr[p]   = arr_q[p];
         judged[p]    = 1'b0;
         judge_ind[p] = IND_BAD;
         score_add[p] = 2'd0;
         if (run && press_valid[p]) begin
            judged[p] = 1'b1;
            if (press_code[p] != 3'b000) begin
               if (arr_q[p][3*JUDGE_SLOT +: 3] == press_code[p]) begin
                  judge_ind[p]                   = IND_EXCELLENT;
                  score_add[p]                   = 2'd2;
                  arr_clr[p][3*JUDGE_SLOT +: 3]  = 3'b000;
               end else if (arr_q[p][3*(JUDGE_SLOT+1) +: 3] == press_code[p]) begin
                  judge_ind[p]                      = IND_GOOD;
                  score_add[p]                      = 2'd1;
                  arr_clr[p][3*(JUDGE_SLOT+1) +: 3] = 3'b000;
               end else if (arr_q[p][3*(JUDGE_SLOT-1) +: 3] == press_code[p]) begin
                  judge_ind[p]                      = IND_GOOD;
                  score_add[p]                      = 2'd1;
                  arr_clr[p][3*(JUDGE_SLOT-1) +: 3] = 3'b000;
               end
            end
         end
         arr_nxt[p]   = step_cycle ? {arr_clr[p][ARRAY_W-4:0], load_code} : arr_clr[p];
         miss[p]      = step_cycle && (arr_clr[p][ARRAY_W-1 -: 3] != 3'b000);
         score_sum[p] = {1'b0, score_q[p]} + 17'(score_add[p]);
         score_nxt[p] = score_sum[p][16] ? 16'hFFFF : score_sum[p][15:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         frame_cnt <= 8'd0;
         step      <= 1'b0;
      end else begin
         if (run && frame_tick) begin
            frame_cnt <= step_cycle ? 8'd0 : frame_cnt + 8'd1;
         end
         step <= step_cycle;
      end
   end

   // A press judgment outranks a same-cycle miss; otherwise the hold counter
   // ages the indicator on frame ticks and blanks it when it runs out.
   always_ff @(posedge clock) begin
      for (int p = 0; p < 2; p++) begin
         if (reset) begin
            arr_q[p]   <= '0;
            ind_q[p]   <= IND_NONE;
            hold_q[p]  <= 8'd0;
            score_q[p] <= 16'd0;
         end else begin
            arr_q[p]   <= arr_nxt[p];
            score_q[p] <= score_nxt[p];
            if (judged[p]) begin
               ind_q[p]  <= judge_ind[p];
               hold_q[p] <= HOLD_INIT;
            end else if (miss[p]) begin
               ind_q[p]  <= IND_BAD;
               hold_q[p] <= HOLD_INIT;
            end else if (run && frame_tick && (hold_q[p] != 8'd0)) begin
               hold_q[p] <= hold_q[p] - 8'd1;
               if (hold_q[p] == 8'd1) begin
                  ind_q[p] <= IND_NONE;
               end
            end
         end
      end
   end

   assign p1_arrow_array = arr_q[0];
   assign p2_arrow_array = arr_q[1];
   assign p1_indicator   = ind_q[0];
   assign p2_indicator   = ind_q[1];
   assign p1_score       = score_q[0];
   assign p2_score       = score_q[1];

endmodule

// File: doc/arrow_stream_scheduler.md
# arrow_stream_scheduler

Sequences the scrolling arrow lanes for both players. Each frame it advances a frame counter, and every FRAMES_PER_STEP frames it shifts each player's 26-slot arrow array down one slot, loading a new arrow from the pattern source into slot 0. It judges player button presses against the hit window and drives the 2-bit judgment indicators and scores. Its array and indicator outputs feed the background/arrow pixel index identifier directly.

## Interface
- FRAMES_PER_STEP, 4: frames between array shifts (legal range 1..255).
- INDICATOR_HOLD, 30: frames a judgment stays on the indicator (legal range 1..255).
- JUDGE_SLOT, 22: slot index for an "excellent" hit; slots JUDGE_SLOT±1 give "good".

- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- run  in  1  game active; when 0 all state holds and presses are ignored.
- frame_tick  in  1  single-cycle pulse once per video frame.
- arrow_valid  in  1  pattern source has an arrow code.
- arrow_code  in  3  arrow code: up 001, left 010, down 011, right 100, shake 110.
- arrow_ready  out  1  combinational; high only in a step cycle.
- p1_press_valid, p2_press_valid  in  1  single-cycle press pulse.
- p1_press_code, p2_press_code  in  3  pressed lane code (same encoding as arrow_code).
- p1_arrow_array, p2_arrow_array  out  78  slot k occupies bits [3k+2:3k]; slot 0 is the top of the screen.
- p1_indicator, p2_indicator  out  2  11 excellent, 10 good, 01 bad/miss, 00 none.
- p1_score, p2_score  out  16  saturating score.
- step  out  1  registered pulse, one cycle after each shift.

## Operation
- frame_cnt is 8 bits. On frame_tick with run=1: if frame_cnt==FRAMES_PER_STEP-1, it wraps to 0 and the cycle is a step cycle; otherwise it increments.
- arrow_ready = run & frame_tick & (frame_cnt==FRAMES_PER_STEP-1).
- Step cycle:
  - Every slot k≥1 takes the value of slot k-1.
  - Slot 0 takes arrow_code if arrow_valid is high and the code is legal.
  - Slot 0 takes 000 if arrow_valid is low, or if the code is illegal (000, 101, 111); the handshake still completes.
  - Both players load the same code into slot 0.
- Miss: on a step, if a player's outgoing slot 25 is non-zero, that player's indicator becomes 01 and the hold counter reloads.
- Press judgment (run=1, pX_press_valid=1) uses the array contents present in that cycle:
  - If slot JUDGE_SLOT matches the press code: excellent (11), +2 score.
  - Else if slot JUDGE_SLOT+1 matches, then slot JUDGE_SLOT-1: good (10), +1 score.
  - Else: bad (01), score unchanged.
  - The matched slot clears to 000 in that player's array only.
  - A press code of 000 always judges bad.
- Same-cycle press and step: the next array is shift(clear(current)). The miss check uses slot 25 after the clear. If a press judgment and a miss occur together, the press judgment sets the indicator.
- Indicator hold:
  - Each judgment reloads a per-player 8-bit counter to INDICATOR_HOLD.
  - The counter decrements on frame_tick while run=1 and it is non-zero.
  - When it reaches 0 the indicator becomes 00.
  - A new judgment overrides the current one immediately.
- Scores saturate at 16'hFFFF.
- run=0: frame_cnt, arrays, hold counters and scores all hold. arrow_ready=0 and presses are dropped.

## Timing
- Reset values:
  - arrays 0, indicators 00, scores 0;
  - frame_cnt 0, hold counters 0;
  - step 0; arrow_ready 0 while reset is high.
- Reset asserted mid-game clears all state at the next edge and overrides any same-cycle step or press.
- All outputs except arrow_ready are registered. Arrays, indicators and scores update on the edge ending the step or press cycle, so they are visible the next cycle.
- The first step occurs on the FRAMES_PER_STEP-th frame_tick after reset.
- An arrow accepted at a step reaches slot 25 after 25 further steps and falls off on the 26th.

## Test plan
- Reset, run=1, FRAMES_PER_STEP=4, arrow_valid=1, code 001 held → arrow_ready pulses on frame_ticks 4, 8, 12…; after 3 steps p1_arrow_array[8:0]=9'b001001001 and p2 is identical.
- Feed a single 010 then idle; after 22 steps, press p1 code 010 → p1_indicator=11, p1_score=2, p1 slot 22=000, p2 slot 22=010 unchanged.
- Press 010 with the arrow at slot 23, and separately at slot 21 → indicator 10, score +1 each; press 100 with no matching arrow → indicator 01, score unchanged.
- Unhit arrow shifted out of slot 25 → p1 and p2 indicators 01; after INDICATOR_HOLD=30 further frame_ticks → 00.
- Press in the same cycle as a step, with the arrow at slot 25 matching nothing → indicator 01 from the press, not a double count; array shifted correctly. Assert reset mid-run → all outputs 0 next cycle.
- run=0 for 10 frame_ticks with presses applied → arrays, scores, indicators and frame_cnt unchanged; arrow_ready stays 0.
